// File: rtl/ir_cmd_ctrl_if.sv
// Signal bundle between the NEC receiver / CPU side and ir_cmd_ctrl.
// The controller connects through the slave modport; the driver side uses master.
interface ir_cmd_ctrl_if;
    logic [31:0] ir_code;
    logic        ir_code_ack;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [24:0] cfg_data;
    logic        evt_valid;
    logic [1:0]  evt_type;
    logic [3:0]  evt_idx;
    logic        evt_ready;
    logic        evt_ovf;
    logic        ovf_clr;

    modport master (
        output ir_code, ir_code_ack, cfg_we, cfg_addr, cfg_data, evt_ready, ovf_clr,
        input  evt_valid, evt_type, evt_idx, evt_ovf
    );

    modport slave (
        input  ir_code, ir_code_ack, cfg_we, cfg_addr, cfg_data, evt_ready, ovf_clr,
        output evt_valid, evt_type, evt_idx, evt_ovf
    );
endinterface

// File: rtl/ir_cmd_ctrl.sv
// NEC IR key-event controller: keymap lookup, press/repeat/release sequencing, 4-deep event FIFO.
// Define IR_CTRL_AUTOREPEAT_EN to build the auto-repeat state and counter.
module ir_cmd_ctrl #(
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 7500000
) (
    input logic           clk50,
    input logic           reset_n,
    ir_cmd_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_HELD_DLY   = 2'd1;
`ifdef IR_CTRL_AUTOREPEAT_EN
    localparam logic [1:0] ST_HELD_RPT   = 2'd2;
    localparam logic [24:0] DLY_LAST     = 25'(REPEAT_DELAY - 1);
    localparam logic [24:0] RATE_LAST    = 25'(REPEAT_RATE - 1);
`endif
    localparam logic [1:0] ST_PRESS_PEND = 2'd3;

    localparam logic [1:0] EVT_PRESS   = 2'b01;
`ifdef IR_CTRL_AUTOREPEAT_EN
    localparam logic [1:0] EVT_REPEAT  = 2'b10;
`endif
    localparam logic [1:0] EVT_RELEASE = 2'b11;

    // ------------------------------------------------------------------
    // Keymap and lookup
    // ------------------------------------------------------------------
    logic [24:0] km_q [16];
    logic [24:0] km_d [16];
    logic [15:0] hit;
    logic        hit_any;
    logic [3:0]  hit_idx;

    for (genvar gi = 0; gi < 16; gi++) begin : g_keymap
        always_comb begin
            km_d[gi] = km_q[gi];
            if (bus.cfg_we && (bus.cfg_addr == 4'(gi)))
                km_d[gi] = bus.cfg_data;
        end

        always_ff @(posedge clk50 or negedge reset_n) begin
            if (!reset_n)
                km_q[gi] <= '0;
            else
                km_q[gi] <= km_d[gi];
        end

        assign hit[gi] = km_q[gi][24]
                      && (km_q[gi][23:8] == bus.ir_code[31:16])
                      && (km_q[gi][7:0]  == bus.ir_code[15:8]);
    end

    // Descending scan so the lowest hitting index is the one left standing
    always_comb begin
        hit_any = 1'b0;
        hit_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                hit_idx = 4'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Key-state FSM
    // ------------------------------------------------------------------
    logic [1:0] state_q, state_d;
    logic [3:0] hidx_q, hidx_d;
    logic [3:0] pidx_q, pidx_d;
`ifdef IR_CTRL_AUTOREPEAT_EN
    logic [24:0] cnt_q, cnt_d;
`endif
    logic       push;
    logic [1:0] push_type;
    logic [3:0] push_idx;
    logic       code_zero;

    assign code_zero = (bus.ir_code == 32'd0);

    always_comb begin
        state_d   = state_q;
        hidx_d    = hidx_q;
        pidx_d    = pidx_q;
`ifdef IR_CTRL_AUTOREPEAT_EN
        cnt_d     = cnt_q;
`endif
        push      = 1'b0;
        push_type = 2'b00;
        push_idx  = 4'd0;

        case (state_q)
            ST_IDLE: begin
                if (bus.ir_code_ack && hit_any) begin
                    push      = 1'b1;
                    push_type = EVT_PRESS;
                    push_idx  = hit_idx;
                    hidx_d    = hit_idx;
`ifdef IR_CTRL_AUTOREPEAT_EN
                    cnt_d     = 25'd0;
`endif
                    state_d   = ST_HELD_DLY;
                end
            end

            ST_PRESS_PEND: begin
                // A new ack in this cycle is intentionally lost
                push      = 1'b1;
                push_type = EVT_PRESS;
                push_idx  = pidx_q;
                hidx_d    = pidx_q;
`ifdef IR_CTRL_AUTOREPEAT_EN
                cnt_d     = 25'd0;
`endif
                state_d   = ST_HELD_DLY;
            end

            default: begin
                if (bus.ir_code_ack) begin
                    push      = 1'b1;
                    push_type = EVT_RELEASE;
                    push_idx  = hidx_q;
                    if (hit_any) begin
                        pidx_d  = hit_idx;
                        state_d = ST_PRESS_PEND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (code_zero) begin
                    push      = 1'b1;
                    push_type = EVT_RELEASE;
                    push_idx  = hidx_q;
                    state_d   = ST_IDLE;
                end
`ifdef IR_CTRL_AUTOREPEAT_EN
                else if ((state_q == ST_HELD_DLY) && (cnt_q == DLY_LAST)) begin
                    push      = 1'b1;
                    push_type = EVT_REPEAT;
                    push_idx  = hidx_q;
                    cnt_d     = 25'd0;
                    state_d   = ST_HELD_RPT;
                end else if ((state_q == ST_HELD_RPT) && (cnt_q == RATE_LAST)) begin
                    push      = 1'b1;
                    push_type = EVT_REPEAT;
                    push_idx  = hidx_q;
                    cnt_d     = 25'd0;
                end else begin
                    cnt_d = cnt_q + 25'd1;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            hidx_q  <= 4'd0;
            pidx_q  <= 4'd0;
`ifdef IR_CTRL_AUTOREPEAT_EN
            cnt_q   <= 25'd0;
`endif
        end else begin
            state_q <= state_d;
            hidx_q  <= hidx_d;
            pidx_q  <= pidx_d;
`ifdef IR_CTRL_AUTOREPEAT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [5:0] fifo_q [4];
    logic [5:0] fifo_d [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       ovf_q, ovf_d;
    logic       pop, full, push_ok, ovf_set;
    logic [5:0] head;

    assign pop     = (count_q != 3'd0) && bus.evt_ready;
    assign full    = (count_q == 3'd4);
    // When full, a simultaneous pop frees the slot the write lands in
    assign push_ok = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    for (genvar gi = 0; gi < 4; gi++) begin : g_fifo
        always_comb begin
            fifo_d[gi] = fifo_q[gi];
            if (push_ok && (wr_ptr_q == 2'(gi)))
                fifo_d[gi] = {push_type, push_idx};
        end

        always_ff @(posedge clk50 or negedge reset_n) begin
            if (!reset_n)
                fifo_q[gi] <= 6'd0;
            else
                fifo_q[gi] <= fifo_d[gi];
        end
    end

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + 2'd1 : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (ovf_set)
            ovf_d = 1'b1;
        else if (bus.ovf_clr)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign head          = fifo_q[rd_ptr_q];
    assign bus.evt_valid = (count_q != 3'd0);
    assign bus.evt_type  = bus.evt_valid ? head[5:4] : 2'b00;
    assign bus.evt_idx   = bus.evt_valid ? head[3:0] : 4'd0;
    assign bus.evt_ovf   = ovf_q;

endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// Directed, table-driven bench for ir_cmd_ctrl; repeat expectations follow IR_CTRL_AUTOREPEAT_EN.
module tb_ir_cmd_ctrl;

    localparam int unsigned DLY  = 100;
    localparam int unsigned RATE = 20;

    localparam logic [31:0] CODE_A = 32'h00FF20DF;   // entry 3
    localparam logic [31:0] CODE_B = 32'h00FF40BF;   // entry 5
    localparam logic [31:0] CODE_C = 32'h123456A9;   // entries 2 and 7

    logic clk50 = 1'b0;
    logic reset_n;
    always #5 clk50 = ~clk50;

    ir_cmd_ctrl_if bus ();

    ir_cmd_ctrl #(.REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)) dut (
        .clk50   (clk50),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [31:0] code;
        bit          ack;
        bit          rdy;
        bit          clr;
        bit          ev;
        logic [1:0]  et;
        logic [3:0]  ei;
        bit          ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic write_key(input logic [3:0] a, input logic [15:0] ad, input logic [7:0] c);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_data = {1'b1, ad, c};
        tick();
        bus.cfg_we   = 1'b0;
        $display("cfg write idx=%0d addr=0x%04h cmd=0x%02h", a, ad, c);
    endtask

    task automatic add(input string name, input logic [31:0] code, input bit ack, input bit rdy,
                       input bit clr, input bit ev, input logic [1:0] et, input logic [3:0] ei,
                       input bit ovf);
        vec_t v;
        v.name = name; v.code = code; v.ack = ack; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.et = et; v.ei = ei; v.ovf = ovf;
        vecs.push_back(v);
    endtask

    initial begin
        int         exp_k[$];
        logic [5:0] exp_v[$];
        int         got_k[$];
        logic [5:0] got_v[$];
        bit         saw_valid;

        reset_n          = 1'b0;
        bus.ir_code      = 32'd0;
        bus.ir_code_ack  = 1'b0;
        bus.cfg_we       = 1'b0;
        bus.cfg_addr     = 4'd0;
        bus.cfg_data     = 25'd0;
        bus.evt_ready    = 1'b1;
        bus.ovf_clr      = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;

        check("reset_valid", bus.evt_valid, 0);
        check("reset_type",  bus.evt_type,  0);
        check("reset_idx",   bus.evt_idx,   0);
        check("reset_ovf",   bus.evt_ovf,   0);

        // Empty keymap: an acked code produces nothing
        bus.ir_code = CODE_A; bus.ir_code_ack = 1'b1;
        tick();
        bus.ir_code_ack = 1'b0;
        check("nomap_valid_0", bus.evt_valid, 0);
        tick();
        check("nomap_valid_1", bus.evt_valid, 0);
        $display("ack 0x%08h with empty keymap -> valid=%0b", CODE_A, bus.evt_valid);

        write_key(4'd3, 16'h00FF, 8'h20);
        write_key(4'd5, 16'h00FF, 8'h40);
        write_key(4'd7, 16'h1234, 8'h56);
        write_key(4'd2, 16'h1234, 8'h56);

        // name, code, ack, rdy, clr, exp valid, type, idx, ovf
        add("press3",        CODE_A, 1, 1, 0, 1, 2'b01, 4'd3, 0);
        add("pop_press3",    CODE_A, 0, 1, 0, 0, 2'b00, 4'd0, 0);
        add("switch_rel3",   CODE_B, 1, 1, 0, 1, 2'b11, 4'd3, 0);
        add("switch_press5", CODE_B, 0, 1, 0, 1, 2'b01, 4'd5, 0);
        add("pop_press5",    CODE_B, 0, 1, 0, 0, 2'b00, 4'd0, 0);
        add("dup_rel5",      CODE_C, 1, 1, 0, 1, 2'b11, 4'd5, 0);
        add("dup_press2",    CODE_C, 0, 1, 0, 1, 2'b01, 4'd2, 0);
        add("pop_press2",    CODE_C, 0, 1, 0, 0, 2'b00, 4'd0, 0);
        add("zero_rel2",     32'd0,  0, 1, 0, 1, 2'b11, 4'd2, 0);
        add("idle_empty",    32'd0,  0, 1, 0, 0, 2'b00, 4'd0, 0);
        add("idle_miss",     32'hDEADBEEF, 1, 1, 0, 0, 2'b00, 4'd0, 0);
        add("pp_press3",     CODE_A, 1, 1, 0, 1, 2'b01, 4'd3, 0);
        add("pp_pop",        CODE_A, 0, 1, 0, 0, 2'b00, 4'd0, 0);
        add("pp_rel3",       CODE_B, 1, 1, 0, 1, 2'b11, 4'd3, 0);
        add("pp_drop_ack",   CODE_A, 1, 1, 0, 1, 2'b01, 4'd5, 0);
        add("pp_held5",      CODE_A, 0, 1, 0, 0, 2'b00, 4'd0, 0);
        add("pp_rel5",       32'd0,  0, 1, 0, 1, 2'b11, 4'd5, 0);
        add("pp_empty",      32'd0,  0, 1, 0, 0, 2'b00, 4'd0, 0);
        add("ovf_fill1",     CODE_A, 1, 0, 0, 1, 2'b01, 4'd3, 0);
        add("ovf_fill2",     CODE_B, 1, 0, 0, 1, 2'b01, 4'd3, 0);
        add("ovf_fill3",     CODE_B, 0, 0, 0, 1, 2'b01, 4'd3, 0);
        add("ovf_fill4",     32'd0,  0, 0, 0, 1, 2'b01, 4'd3, 0);
        add("ovf_drop5",     CODE_A, 1, 0, 0, 1, 2'b01, 4'd3, 1);
        add("ovf_drain1",    CODE_A, 0, 1, 0, 1, 2'b11, 4'd3, 1);
        add("ovf_drain2",    CODE_A, 0, 1, 0, 1, 2'b01, 4'd5, 1);
        add("ovf_drain3",    CODE_A, 0, 1, 0, 1, 2'b11, 4'd5, 1);
        add("ovf_drain4",    CODE_A, 0, 1, 0, 0, 2'b00, 4'd0, 1);
        add("ovf_clear",     CODE_A, 0, 1, 1, 0, 2'b00, 4'd0, 0);
        add("full_fill1",    CODE_B, 1, 0, 0, 1, 2'b11, 4'd3, 0);
        add("full_fill2",    CODE_B, 0, 0, 0, 1, 2'b11, 4'd3, 0);
        add("full_fill3",    CODE_A, 1, 0, 0, 1, 2'b11, 4'd3, 0);
        add("full_fill4",    CODE_A, 0, 0, 0, 1, 2'b11, 4'd3, 0);
        add("full_pushpop",  32'd0,  0, 1, 0, 1, 2'b01, 4'd5, 0);
        add("full_drain1",   32'd0,  0, 1, 0, 1, 2'b11, 4'd5, 0);
        add("full_drain2",   32'd0,  0, 1, 0, 1, 2'b01, 4'd3, 0);
        add("full_drain3",   32'd0,  0, 1, 0, 1, 2'b11, 4'd3, 0);
        add("full_drain4",   32'd0,  0, 1, 0, 0, 2'b00, 4'd0, 0);

        foreach (vecs[i]) begin
            bus.ir_code     = vecs[i].code;
            bus.ir_code_ack = vecs[i].ack;
            bus.evt_ready   = vecs[i].rdy;
            bus.ovf_clr     = vecs[i].clr;
            tick();
            $display("vec %-14s code=0x%08h ack=%0b rdy=%0b -> valid=%0b type=%0d idx=%0d ovf=%0b",
                     vecs[i].name, vecs[i].code, vecs[i].ack, vecs[i].rdy,
                     bus.evt_valid, bus.evt_type, bus.evt_idx, bus.evt_ovf);
            check({vecs[i].name, "_valid"}, bus.evt_valid, vecs[i].ev);
            check({vecs[i].name, "_type"},  bus.evt_type,  vecs[i].et);
            check({vecs[i].name, "_idx"},   bus.evt_idx,   vecs[i].ei);
            check({vecs[i].name, "_ovf"},   bus.evt_ovf,   vecs[i].ovf);
        end
        bus.ir_code_ack = 1'b0;
        bus.ovf_clr     = 1'b0;
        bus.evt_ready   = 1'b1;

        // Hold key 3 for 150 cycles; each event is popped the cycle it appears
        exp_k.push_back(0);   exp_v.push_back({2'b01, 4'd3});
`ifdef IR_CTRL_AUTOREPEAT_EN
        exp_k.push_back(100); exp_v.push_back({2'b10, 4'd3});
        exp_k.push_back(120); exp_v.push_back({2'b10, 4'd3});
        exp_k.push_back(140); exp_v.push_back({2'b10, 4'd3});
`endif
        exp_k.push_back(150); exp_v.push_back({2'b11, 4'd3});

        bus.ir_code     = CODE_A;
        bus.ir_code_ack = 1'b1;
        for (int k = 0; k <= 170; k++) begin
            if (k == 150) bus.ir_code = 32'd0;
            tick();
            bus.ir_code_ack = 1'b0;
            if (bus.evt_valid) begin
                got_k.push_back(k);
                got_v.push_back({bus.evt_type, bus.evt_idx});
                $display("hold cycle %0d: type=%0d idx=%0d", k, bus.evt_type, bus.evt_idx);
            end
        end
        check("hold_event_count", got_k.size(), exp_k.size());
        for (int i = 0; i < exp_k.size() && i < got_k.size(); i++) begin
            check($sformatf("hold_ev%0d_cycle", i), got_k[i], exp_k[i]);
            check($sformatf("hold_ev%0d_evt", i),   got_v[i], exp_v[i]);
        end

        // Reset in the middle of a hold with a press still queued
        bus.evt_ready   = 1'b0;
        bus.ir_code     = CODE_A;
        bus.ir_code_ack = 1'b1;
        tick();
        bus.ir_code_ack = 1'b0;
        check("midhold_press_valid", bus.evt_valid, 1);
        check("midhold_press_type",  bus.evt_type,  2'b01);
        repeat (5) tick();
        #2;
        reset_n = 1'b0;
        #1;
        $display("reset asserted mid-hold -> valid=%0b type=%0d idx=%0d ovf=%0b",
                 bus.evt_valid, bus.evt_type, bus.evt_idx, bus.evt_ovf);
        check("midreset_valid", bus.evt_valid, 0);
        check("midreset_type",  bus.evt_type,  0);
        check("midreset_idx",   bus.evt_idx,   0);
        check("midreset_ovf",   bus.evt_ovf,   0);
        tick();
        tick();
        reset_n       = 1'b1;
        bus.evt_ready = 1'b1;
        bus.ir_code   = 32'd0;
        saw_valid     = 1'b0;
        repeat (10) begin
            tick();
            if (bus.evt_valid) saw_valid = 1'b1;
        end
        check("postreset_no_release", saw_valid, 0);

        // Keymap was cleared by reset, so the old code no longer maps
        bus.ir_code     = CODE_A;
        bus.ir_code_ack = 1'b1;
        tick();
        bus.ir_code_ack = 1'b0;
        saw_valid = bus.evt_valid;
        repeat (2) begin
            tick();
            if (bus.evt_valid) saw_valid = 1'b1;
        end
        check("postreset_keymap_clear", saw_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
